fifo_access_sched: RTL and testbench

//  Sequences all access to the 16x8 shift-register FIFO: shares its single write port between
//  NUM_REQ producers (round-robin) and its read port with one consumer. Issues at most one FIFO
//  op per cycle, because a same-cycle write+read corrupts the FIFO write pointer. Keeps its own

---
 rtl/fifo_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/fifo_access_sched.sv | 158 +++++++++++++++
 tb/tb_fifo_access_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the FIFO access scheduler.
// Optional statistics are enabled by defining FIFO_SCHED_STATS_EN.
package fifo_sched_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } op_e;

    localparam int STAT_W = 16;

    // Saturating increment used by the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_access_sched.sv
// Serialises producer writes and consumer reads onto a single-op-per-cycle FIFO port.
// Define FIFO_SCHED_STATS_EN to add per-requester grant and full-stall counters.
module fifo_access_sched
    import fifo_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int CAPACITY = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              wr_req,
    input  logic [NUM_REQ*DATA_W-1:0]       wr_data,
    output logic [NUM_REQ-1:0]              wr_gnt,
    input  logic                            rd_req,
    output logic                            rd_valid,
    output logic [DATA_W-1:0]               rd_data,
    output logic [$clog2(CAPACITY+1)-1:0]   level,
    output logic                            full,
    output logic                            empty,
    output logic                            fifo_en_write,
    output logic                            fifo_en_read,
    output logic [DATA_W-1:0]               fifo_data_in,
    input  logic [DATA_W-1:0]               fifo_data_out
`ifdef FIFO_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]       wr_cnt,
    output logic [STAT_W-1:0]               stall_cnt
`endif
);

    localparam int LVL_W = $clog2(CAPACITY + 1);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [LVL_W-1:0] CAP_L    = LVL_W'(CAPACITY);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_e            state_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              prio_q, prio_d;   // 0: write wins a tie, 1: read wins
    logic              rd_ok_q;
    logic              rd_valid_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               wr_any, wr_elig, rd_elig;
    op_e                op;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (wr_req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // rd_ok_q lags the level by a cycle to cover the FIFO's late underflow flag.
    assign wr_any  = |wr_req;
    assign wr_elig = wr_any && (level_q < CAP_L);
    assign rd_elig = rd_req && rd_ok_q && (state_q == IDLE) && (level_q != '0);

    always_comb begin
        op = OP_NONE;
        if (wr_elig && rd_elig) begin
            op = prio_q ? OP_RD : OP_WR;
        end else if (wr_elig) begin
            op = OP_WR;
        end else if (rd_elig) begin
            op = OP_RD;
        end
    end

    always_comb begin
        level_d = level_q;
        ptr_d   = ptr_q;
        prio_d  = (wr_elig && rd_elig) ? ~prio_q : prio_q;
        case (op)
            OP_WR: begin
                level_d = level_q + 1'b1;
                ptr_d   = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
            end
            OP_RD:   level_d = level_q - 1'b1;
            default: ;
        endcase
    end

    assign wr_gnt        = (op == OP_WR) ? arb_gnt : '0;
    assign fifo_en_write = (op == OP_WR);
    assign fifo_en_read  = (op == OP_RD);
    assign fifo_data_in  = (op == OP_WR) ? wr_data[arb_idx*DATA_W +: DATA_W] : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            level_q    <= '0;
            ptr_q      <= '0;
            prio_q     <= 1'b0;
            rd_ok_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            level_q <= level_d;
            ptr_q   <= ptr_d;
            prio_q  <= prio_d;
            rd_ok_q <= (level_q != '0);
            case (state_q)
                IDLE: begin
                    if (op == OP_RD) begin
                        state_q    <= RD_WAIT;
                        rd_valid_q <= 1'b1;
                    end else begin
                        rd_valid_q <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    state_q    <= IDLE;
                    rd_valid_q <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    rd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // FIFO data_out is registered, so the popped word is present during RD_WAIT.
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_valid_q ? fifo_data_out : '0;
    assign level    = level_q;
    assign full     = (level_q == CAP_L);
    assign empty    = (level_q == '0);

`ifdef FIFO_SCHED_STATS_EN
    logic [STAT_W-1:0] wr_cnt_q [NUM_REQ];
    logic [STAT_W-1:0] stall_cnt_q;

    // NOTE: the counter array is small and must read 0 after reset, so every entry is reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) wr_cnt_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (wr_gnt[i]) wr_cnt_q[i] <= sat_inc(wr_cnt_q[i]);
            end
            if (wr_any && full) stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign wr_cnt[g*STAT_W +: STAT_W] = wr_cnt_q[g];
    end
    assign stall_cnt = stall_cnt_q;
`else
    // Statistics disabled: no counters, scheduling unchanged.
`endif

endmodule

// File: tb/tb_fifo_access_sched.sv
// Randomised and directed bench for fifo_access_sched against a cycle-level reference model.
// Define FIFO_SCHED_STATS_EN to also check the statistics counters.
module tb_fifo_access_sched;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CAP = 15;
    localparam int LW  = $clog2(CAP + 1);
    localparam int SW  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      wr_req;
    logic [N*DW-1:0]   wr_data;
    logic [N-1:0]      wr_gnt;
    logic              rd_req;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic [LW-1:0]     level;
    logic              full, empty;
    logic              fifo_en_write, fifo_en_read;
    logic [DW-1:0]     fifo_data_in;
    logic [DW-1:0]     fifo_data_out;
`ifdef FIFO_SCHED_STATS_EN
    logic [N*SW-1:0]   wr_cnt;
    logic [SW-1:0]     stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo_access_sched #(.NUM_REQ(N), .DATA_W(DW), .CAPACITY(CAP)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_req        (wr_req),
        .wr_data       (wr_data),
        .wr_gnt        (wr_gnt),
        .rd_req        (rd_req),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .fifo_en_write (fifo_en_write),
        .fifo_en_read  (fifo_en_read),
        .fifo_data_in  (fifo_data_in),
        .fifo_data_out (fifo_data_out)
`ifdef FIFO_SCHED_STATS_EN
        ,
        .wr_cnt        (wr_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    // Physical FIFO stand-in with a registered data_out.
    logic [DW-1:0] phys_q[$];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            phys_q.delete();
            fifo_data_out <= '0;
        end else begin
            if (fifo_en_write) phys_q.push_back(fifo_data_in);
            if (fifo_en_read && phys_q.size() > 0) fifo_data_out <= phys_q.pop_front();
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int            m_level, m_ptr;
    bit            m_rd_ok, m_pend, m_prio, m_rd_valid;
    logic [DW-1:0] m_rd_data;
    logic [DW-1:0] exp_q[$];
    int            m_wr_cnt[N];
    int            m_stall;

    // Per-cycle observations for directed tests.
    int            last_k;
    bit            last_rd, last_rvalid;
    logic [DW-1:0] obs_rd_data;

    task automatic model_reset();
        m_level = 0; m_ptr = 0; m_rd_ok = 0; m_pend = 0; m_prio = 0;
        m_rd_valid = 0; m_rd_data = '0; exp_q.delete(); m_stall = 0;
        for (int i = 0; i < N; i++) m_wr_cnt[i] = 0;
        last_k = -1; last_rd = 0; last_rvalid = 0;
    endtask

    // One clock cycle: compare DUT to the model before the edge, then advance the model.
    task automatic tick();
        bit           w_el, r_el, do_w, do_r;
        int           k;
        logic [N-1:0] g_exp;
        #1;
        w_el = (wr_req != '0) && (m_level < CAP);
        r_el = rd_req && m_rd_ok && !m_pend;
        do_w = 0; do_r = 0;
        if (w_el && r_el) begin do_w = !m_prio; do_r = m_prio; end
        else if (w_el) do_w = 1;
        else if (r_el) do_r = 1;
        k = -1;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (k < 0 && wr_req[j]) k = j;
        end
        g_exp = '0;
        if (do_w) g_exp[k] = 1'b1;

        checks++; if (wr_gnt !== g_exp) begin errors++;
            $display("FAIL wr_gnt t=%0t got %b exp %b", $time, wr_gnt, g_exp); end
        checks++; if (fifo_en_write !== do_w) begin errors++;
            $display("FAIL en_write t=%0t got %b exp %b", $time, fifo_en_write, do_w); end
        checks++; if (fifo_en_read !== do_r) begin errors++;
            $display("FAIL en_read t=%0t got %b exp %b", $time, fifo_en_read, do_r); end
        checks++; if ((fifo_en_write & fifo_en_read) !== 1'b0) begin errors++;
            $display("FAIL dual_op t=%0t got 1 exp 0", $time); end
        if (do_w) begin
            checks++; if (fifo_data_in !== wr_data[k*DW +: DW]) begin errors++;
                $display("FAIL data_in t=%0t got %h exp %h", $time, fifo_data_in, wr_data[k*DW +: DW]); end
        end
        checks++; if (rd_valid !== m_rd_valid) begin errors++;
            $display("FAIL rd_valid t=%0t got %b exp %b", $time, rd_valid, m_rd_valid); end
        if (m_rd_valid) begin
            checks++; if (rd_data !== m_rd_data) begin errors++;
                $display("FAIL rd_data t=%0t got %h exp %h", $time, rd_data, m_rd_data); end
        end
        checks++; if (level !== LW'(m_level)) begin errors++;
            $display("FAIL level t=%0t got %0d exp %0d", $time, level, m_level); end
        checks++; if (full !== (m_level == CAP) || empty !== (m_level == 0)) begin errors++;
            $display("FAIL flags t=%0t got full=%b empty=%b exp level=%0d", $time, full, empty, m_level); end
`ifdef FIFO_SCHED_STATS_EN
        checks++; if (stall_cnt !== SW'(m_stall)) begin errors++;
            $display("FAIL stall_cnt t=%0t got %0d exp %0d", $time, stall_cnt, m_stall); end
        for (int i = 0; i < N; i++) begin
            checks++; if (wr_cnt[i*SW +: SW] !== SW'(m_wr_cnt[i])) begin errors++;
                $display("FAIL wr_cnt%0d t=%0t got %0d exp %0d", i, $time, wr_cnt[i*SW +: SW], m_wr_cnt[i]); end
        end
`endif
        obs_rd_data = rd_data;
        last_rvalid = m_rd_valid;
        last_k      = do_w ? k : -1;
        last_rd     = do_r;
        if (wr_req != '0 && m_level == CAP && m_stall < 16'hFFFF) m_stall++;

        @(posedge clk);
        m_rd_ok    = (m_level >= 1);
        m_pend     = do_r;
        m_rd_valid = do_r;
        m_rd_data  = '0;
        if (w_el && r_el) m_prio = !m_prio;
        if (do_w) begin
            exp_q.push_back(wr_data[k*DW +: DW]);
            m_ptr = (k + 1) % N;
            m_level++;
            if (m_wr_cnt[k] < 16'hFFFF) m_wr_cnt[k]++;
        end
        if (do_r) begin
            m_level--;
            if (exp_q.size() > 0) m_rd_data = exp_q.pop_front();
        end
        @(negedge clk);
    endtask

    // Producers hold until granted; consumer holds until rd_valid.
    task automatic auto_stim(input int wr_pct, input int rd_pct);
        for (int i = 0; i < N; i++) begin
            if (last_k == i || !wr_req[i]) begin
                wr_req[i] = ($urandom_range(99) < wr_pct);
                wr_data[i*DW +: DW] = DW'($urandom);
            end
        end
        if (last_rvalid || !rd_req) rd_req = ($urandom_range(99) < rd_pct);
    endtask

    task automatic do_reset();
        wr_req = '0; rd_req = 1'b0; wr_data = '0;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        wr_req = '0; rd_req = 1'b0; wr_data = '0;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (wr_gnt !== '0 || fifo_en_write !== 1'b0 || fifo_en_read !== 1'b0) begin errors++;
            $display("FAIL reset_ctl got gnt=%b w=%b r=%b exp 0", wr_gnt, fifo_en_write, fifo_en_read); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin errors++;
            $display("FAIL reset_rd got v=%b d=%h exp 0", rd_valid, rd_data); end
        checks++; if (level !== '0 || empty !== 1'b1 || full !== 1'b0) begin errors++;
            $display("FAIL reset_lvl got level=%0d empty=%b full=%b exp 0/1/0", level, empty, full); end
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_single_producer();
        logic [DW-1:0] words[3];
        logic [DW-1:0] got[$];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        do_reset();
        for (int w = 0; w < 3; w++) begin
            int n;
            wr_req = 4'b0001; wr_data = '0; wr_data[DW-1:0] = words[w];
            n = 0;
            do begin tick(); n++; end while (last_k != 0 && n < 10);
            checks++; if (last_k != 0) begin errors++;
                $display("FAIL single_wr%0d got no grant exp grant", w); end
        end
        wr_req = '0;
        rd_req = 1'b1;
        for (int c = 0; c < 30 && got.size() < 3; c++) begin
            tick();
            if (last_rvalid) begin
                got.push_back(obs_rd_data);
                if (got.size() == 3) rd_req = 1'b0;
            end
        end
        rd_req = 1'b0;
        checks++; if (got.size() != 3) begin errors++;
            $display("FAIL single_pops got %0d exp 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++; if (got[i] !== words[i]) begin errors++;
                $display("FAIL single_order%0d got %h exp %h", i, got[i], words[i]); end
        end
        tick();
        checks++; if (level !== '0 || empty !== 1'b1) begin errors++;
            $display("FAIL single_drain got level=%0d exp 0", level); end
    endtask

    task automatic test_round_robin();
        int order[5];
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        wr_req = '1;
        for (int i = 0; i < N; i++) wr_data[i*DW +: DW] = DW'($urandom);
        for (int c = 0; c < 5; c++) begin
            tick();
            order[c] = last_k;
            if (last_k >= 0) wr_data[last_k*DW +: DW] = DW'($urandom);
        end
        for (int c = 0; c < 5; c++) begin
            checks++; if (order[c] != exp_order[c]) begin errors++;
                $display("FAIL rr_order%0d got %0d exp %0d", c, order[c], exp_order[c]); end
        end
    endtask

    task automatic test_full();
        int grants, n;
        bit resumed;
        do_reset();
        wr_req = '1;
        grants = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (last_k >= 0) begin grants++; wr_data[last_k*DW +: DW] = DW'($urandom); end
        end
        checks++; if (grants != CAP || full !== 1'b1) begin errors++;
            $display("FAIL full_fill got grants=%0d full=%b exp %0d/1", grants, full, CAP); end
        rd_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!last_rd && n < 10);
        checks++; if (!last_rd) begin errors++;
            $display("FAIL full_pop got no read exp read"); end
        tick();
        resumed = (last_k >= 0);
        rd_req = 1'b0;
        checks++; if (!resumed) begin errors++;
            $display("FAIL full_resume got no grant exp grant"); end
        wr_req = '0;
        tick();
    endtask

    task automatic test_read_latency();
        int n;
        do_reset();
        rd_req = 1'b1;
        wr_req = 4'b0010; wr_data[1*DW +: DW] = 8'hA5;
        tick();
        checks++; if (last_k != 1) begin errors++;
            $display("FAIL lat_write got k=%0d exp 1", last_k); end
        wr_req = '0;
        tick();
        checks++; if (last_rd) begin errors++;
            $display("FAIL lat_t1 got read exp none"); end
        tick();
        checks++; if (!last_rd) begin errors++;
            $display("FAIL lat_t2 got none exp read"); end
        tick();
        checks++; if (!last_rvalid || obs_rd_data !== 8'hA5) begin errors++;
            $display("FAIL lat_data got v=%b d=%h exp 1/a5", last_rvalid, obs_rd_data); end
        rd_req = 1'b0;
        n = 0;
        tick();
    endtask

    task automatic test_alternate();
        int nw, nr, idle;
        do_reset();
        wr_req = 4'b0001; wr_data[DW-1:0] = DW'($urandom);
        for (int c = 0; c < 4; c++) begin
            tick();
            wr_data[DW-1:0] = DW'($urandom);
        end
        rd_req = 1'b1;
        nw = 0; nr = 0; idle = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (last_k >= 0) nw++;
            if (last_rd) nr++;
            if (last_k < 0 && !last_rd) idle++;
            auto_stim(100, 100);
        end
        checks++; if (nw == 0 || nr == 0 || idle != 0) begin errors++;
            $display("FAIL alt_mix got w=%0d r=%0d idle=%0d exp w>0 r>0 idle=0", nw, nr, idle); end
        wr_req = '0; rd_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int wp[3];
        int rp[3];
        wp = '{70, 30, 90};
        rp = '{30, 80, 90};
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 600; c++) begin
                auto_stim(wp[ph], rp[ph]);
                tick();
            end
        end
        wr_req = '0; rd_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        int n;
        do_reset();
        wr_req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            wr_data[2*DW +: DW] = DW'($urandom);
            tick();
        end
        wr_req = '0;
        rd_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!last_rd && n < 10);
        checks++; if (!last_rd || rd_valid !== 1'b1 || level !== LW'(2)) begin errors++;
            $display("FAIL mid_setup got rd=%b v=%b level=%0d exp 1/1/2", last_rd, rd_valid, level); end
        #1 reset = 1'b1;
        #1;
        checks++; if (rd_valid !== 1'b0 || level !== '0 || empty !== 1'b1 || fifo_en_read !== 1'b0) begin errors++;
            $display("FAIL mid_reset got v=%b level=%0d empty=%b r=%b exp 0/0/1/0",
                     rd_valid, level, empty, fifo_en_read); end
`ifdef FIFO_SCHED_STATS_EN
        checks++; if (wr_cnt !== '0 || stall_cnt !== '0) begin errors++;
            $display("FAIL mid_stats got wr_cnt=%h stall=%0d exp 0", wr_cnt, stall_cnt); end
`endif
        rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    initial begin
        reset = 1'b1; wr_req = '0; rd_req = 1'b0; wr_data = '0;
        model_reset();
        test_reset();
        test_single_producer();
        test_round_robin();
        test_full();
        test_read_latency();
        test_alternate();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
